// File: rtl/seg7_scan_decoder.sv
// Loop-back decoder for a scanned 7-segment bus: waits for each lit digit to settle,
// turns its glyph back into a nibble and publishes the whole value once every digit is seen.
module seg7_scan_decoder #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            hex,
    input  logic [DIGITS-1:0]     AN,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  frame_valid,
    output logic                  an_err
);
    localparam int CW = 8;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] STABLE = CW'(STABLE_CYCLES);

    logic [6:0]          hex_q, hex_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [DIGITS-1:0]   shadow_err_q, shadow_err_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   digit_err_q, digit_err_d;
    logic                frame_valid_q, frame_valid_d;
    logic                an_err_q, an_err_d;

    logic [DIGITS-1:0]   zeros_new, zeros_reg;
    logic                sel_valid, same, capture, publish, glyph_err;
    logic [IW-1:0]       sel_idx;
    logic [3:0]          glyph_nib;

    always_comb begin
        glyph_err = 1'b0;
        glyph_nib = 4'h0;
        case (hex)
            7'b1000000: glyph_nib = 4'h0;
            7'b1111001: glyph_nib = 4'h1;
            7'b0100100: glyph_nib = 4'h2;
            7'b0110000: glyph_nib = 4'h3;
            7'b0011001: glyph_nib = 4'h4;
            7'b0010010: glyph_nib = 4'h5;
            7'b0000010: glyph_nib = 4'h6;
            7'b1111000: glyph_nib = 4'h7;
            7'b0000000: glyph_nib = 4'h8;
            7'b0010000: glyph_nib = 4'h9;
            7'b0001000: glyph_nib = 4'hA;
            7'b0000011: glyph_nib = 4'hB;
            7'b1000110: glyph_nib = 4'hC;
            7'b0100001: glyph_nib = 4'hD;
            7'b0000110: glyph_nib = 4'hE;
            7'b0001110: glyph_nib = 4'hF;
            default:    glyph_err = 1'b1;
        endcase
    end

    // The counter tracks the pair entering in_r, so a pair registered at edge k
    // reaches STABLE on edge k+STABLE_CYCLES-1.
    always_comb begin
        hex_d     = hex;
        an_d      = AN;
        zeros_new = ~AN;
        zeros_reg = ~an_q;
        sel_valid = (zeros_new != '0) && ((zeros_new & (zeros_new - DIGITS'(1))) == '0);
        sel_idx   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (zeros_new[i]) sel_idx = IW'(i);
        end
        same = (hex == hex_q) && (AN == an_q);

        if (sel_valid && same) cnt_d = (cnt_q == STABLE) ? cnt_q : cnt_q + CW'(1);
        else                   cnt_d = sel_valid ? CW'(1) : CW'(0);

        capture = sel_valid && (cnt_d == STABLE) && (cnt_q != STABLE);
        publish = &seen_q;

        an_err_d      = (zeros_reg & (zeros_reg - DIGITS'(1))) != '0;
        frame_valid_d = publish;
        value_d       = publish ? shadow_q : value_q;
        digit_err_d   = publish ? shadow_err_q : digit_err_q;

        // Publishing clears seen first so a coincident capture opens the next frame.
        seen_d       = publish ? '0 : seen_q;
        shadow_d     = shadow_q;
        shadow_err_d = shadow_err_q;
        if (capture) begin
            seen_d[sel_idx]         = 1'b1;
            shadow_err_d[sel_idx]   = glyph_err;
            shadow_d[4*sel_idx +: 4] = glyph_nib;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_q         <= '1;
            an_q          <= '1;
            cnt_q         <= '0;
            seen_q        <= '0;
            shadow_q      <= '0;
            shadow_err_q  <= '0;
            value_q       <= '0;
            digit_err_q   <= '0;
            frame_valid_q <= 1'b0;
            an_err_q      <= 1'b0;
        end else begin
            hex_q         <= hex_d;
            an_q          <= an_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            shadow_q      <= shadow_d;
            shadow_err_q  <= shadow_err_d;
            value_q       <= value_d;
            digit_err_q   <= digit_err_d;
            frame_valid_q <= frame_valid_d;
            an_err_q      <= an_err_d;
        end
    end

    assign value       = value_q;
    assign digit_err   = digit_err_q;
    assign frame_valid = frame_valid_q;
    assign an_err      = an_err_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed and random scans of seg7_scan_decoder against a dwell-length reference model.
module tb_seg7_scan_decoder;
    localparam int D = 8;
    localparam int S = 4;
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    hex = '1;
    logic [D-1:0]  AN = '1;
    logic [4*D-1:0] value;
    logic [D-1:0]  digit_err;
    logic          frame_valid, an_err;

    seg7_scan_decoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .hex(hex), .AN(AN),
        .value(value), .digit_err(digit_err), .frame_valid(frame_valid), .an_err(an_err));

    always #5 clk = ~clk;

    int errors = 0, checks = 0, frames = 0, anerrs = 0;

    // reference model: run length of the applied pair, captures at exactly S
    logic [6:0]     m_hex;
    logic [D-1:0]   m_an;
    int             m_run;
    logic [D-1:0]   m_seen, m_sh_err, m_err;
    logic [4*D-1:0] m_shadow, m_value;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int zcount(input logic [D-1:0] a);
        return $countones(~a);
    endfunction

    task automatic model_reset();
        m_hex = '1; m_an = '1; m_run = 0;
        m_seen = '0; m_sh_err = '0; m_err = '0; m_shadow = '0; m_value = '0;
    endtask

    task automatic cyc(input logic [6:0] h, input logic [D-1:0] a);
        logic exp_fv, exp_an, bad;
        logic [3:0] nib;
        int idx;
        hex = h; AN = a;
        @(posedge clk);
        exp_fv = &m_seen;
        if (exp_fv) begin
            m_value = m_shadow; m_err = m_sh_err; m_seen = '0;
        end
        exp_an = zcount(m_an) >= 2;
        if (h == m_hex && a == m_an) m_run++; else m_run = 1;
        m_hex = h; m_an = a;
        if (zcount(a) == 1 && m_run == S) begin
            idx = 0;
            for (int i = 0; i < D; i++) if (!a[i]) idx = i;
            bad = 1'b1; nib = 4'h0;
            for (int k = 0; k < 16; k++) if (GLYPH[k] == h) begin bad = 1'b0; nib = 4'(k); end
            m_shadow[4*idx +: 4] = nib;
            m_sh_err[idx] = bad;
            m_seen[idx] = 1'b1;
        end
        #1;
        chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
        chk("an_err", 32'(an_err), 32'(exp_an));
        chk("value", value, m_value);
        chk("digit_err", 32'(digit_err), 32'(m_err));
        if (frame_valid) frames++;
        if (an_err) anerrs++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hex = 7'($urandom); AN = 8'($urandom);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_value", value, 32'h0);
        chk("rst_digit_err", 32'(digit_err), 32'h0);
        chk("rst_frame_valid", 32'(frame_valid), 32'h0);
        chk("rst_an_err", 32'(an_err), 32'h0);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic dwell(input int d, input logic [6:0] h, input int n);
        for (int c = 0; c < n; c++) cyc(h, ~(8'b1 << d));
    endtask

    task automatic scan(input logic [31:0] nibs, input int first, input int last);
        for (int d = first; d <= last; d++) dwell(d, GLYPH[nibs[4*d +: 4]], 6);
    endtask

    initial begin
        int f0, a0;
        model_reset();
        do_reset();
        repeat (3) cyc('1, '1);

        // full scan
        f0 = frames;
        scan(32'h87654321, 0, 7);
        chk("scan_frames", 32'(frames - f0), 32'd1);
        chk("scan_value", value, 32'h87654321);
        chk("scan_err", 32'(digit_err), 32'h0);

        // glitch: 3-cycle '7' on digit 0 must never be captured
        f0 = frames;
        dwell(0, GLYPH[7], 3);
        dwell(0, GLYPH[9], 5);
        scan(32'h1111_1119, 1, 7);
        chk("glitch_frames", 32'(frames - f0), 32'd1);
        chk("glitch_value", value, 32'h1111_1119);

        // illegal glyph on digit 2
        for (int d = 0; d < 8; d++) dwell(d, (d == 2) ? 7'h7F : GLYPH[15], 6);
        chk("illegal_value", value, 32'hFFFF_F0FF);
        chk("illegal_err", 32'(digit_err), 32'h04);

        // invalid AN mid-frame leaves seen alone
        f0 = frames; a0 = anerrs;
        scan(32'h0000_4321, 0, 3);
        repeat (5) cyc(GLYPH[8], 8'b1111_1100);
        repeat (3) cyc('1, '1);
        chk("anerr_pulses", 32'(anerrs - a0), 32'd5);
        chk("anerr_noframe", 32'(frames - f0), 32'd0);
        scan(32'hDCBA_0000, 4, 7);
        chk("anerr_resume_frames", 32'(frames - f0), 32'd1);
        chk("anerr_resume_value", value, 32'hDCBA_4321);

        // revisit then mid-frame reset
        f0 = frames;
        dwell(3, GLYPH[5], 5);
        dwell(3, GLYPH[10], 5);
        chk("revisit_noframe", 32'(frames - f0), 32'd0);
        do_reset();
        scan(32'h7654_C210, 0, 6);
        chk("rescan_noframe", 32'(frames - f0), 32'd0);
        scan(32'h7654_C210, 7, 7);
        chk("rescan_frames", 32'(frames - f0), 32'd1);
        chk("rescan_digit3", 32'(value[15:12]), 32'hC);

        // random dwells, occasional bad glyphs or bad AN
        for (int n = 0; n < 400; n++) begin
            logic [6:0] h;
            logic [D-1:0] a;
            int len;
            h = ($urandom_range(9) == 0) ? 7'($urandom) : GLYPH[$urandom_range(15)];
            a = ($urandom_range(11) == 0) ? 8'($urandom) : ~(8'b1 << $urandom_range(7));
            len = $urandom_range(7, 1);
            repeat (len) cyc(h, a);
            if ($urandom_range(29) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
